// File: rtl/pc_sequencer.sv
// Program-counter owner for the single-cycle core: run/halt/step control,
// breakpoint, self-loop and misaligned-target detection, cycle/retire counters.
module pc_sequencer #(
  parameter int              AW       = 32,
  parameter logic [AW-1:0]   RESET_PC = '0,
  parameter int              CW       = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          step_req,
  input  logic          halt_req,
  input  logic          bp_en,
  input  logic [AW-1:0] bp_addr,
  input  logic [AW-1:0] next_addr,
  output logic [AW-1:0] pc,
  output logic          cpu_clk_en,
  output logic          running,
  output logic          halted,
  output logic [2:0]    halt_cause,
  output logic [CW-1:0] cycle_cnt,
  output logic [CW-1:0] retire_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_HALT = 2'd3
  } state_e;

  localparam logic [2:0] CAUSE_NONE  = 3'd0;
  localparam logic [2:0] CAUSE_REQ   = 3'd1;
  localparam logic [2:0] CAUSE_STEP  = 3'd2;
  localparam logic [2:0] CAUSE_BP    = 3'd3;
  localparam logic [2:0] CAUSE_LOOP  = 3'd4;
  localparam logic [2:0] CAUSE_FAULT = 3'd5;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [2:0]    cause_q, cause_d;
  logic          bp_skip_q, bp_skip_d;
  logic [CW-1:0] cycle_q, cycle_d;
  logic [CW-1:0] retire_q, retire_d;

  logic fault;
  logic bp_hit;
  logic active;
  logic retire;

  // The core is single-cycle, so next_addr reflects pc_q within this cycle.
  always_comb begin
    fault  = (next_addr[1:0] != 2'b00);
    bp_hit = bp_en && (pc_q == bp_addr) && !bp_skip_q && (state_q == S_RUN);
    active = (state_q == S_RUN) || (state_q == S_STEP);
    retire = active && !fault && !bp_hit;
  end

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    bp_skip_d = bp_skip_q;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d   = S_RUN;
          cause_d   = CAUSE_NONE;
          // Resuming from HALT must not re-trigger on the breakpoint PC.
          bp_skip_d = (state_q == S_HALT);
        end else if (step_req) begin
          state_d = S_STEP;
          cause_d = CAUSE_NONE;
        end
      end
      S_RUN: begin
        bp_skip_d = 1'b0;
        if (fault) begin
          state_d = S_HALT;
          cause_d = CAUSE_FAULT;
        end else if (bp_hit) begin
          state_d = S_HALT;
          cause_d = CAUSE_BP;
        end else if (next_addr == pc_q) begin
          state_d = S_HALT;
          cause_d = CAUSE_LOOP;
        end else if (halt_req) begin
          state_d = S_HALT;
          cause_d = CAUSE_REQ;
        end
      end
      S_STEP: begin
        state_d = S_HALT;
        cause_d = fault ? CAUSE_FAULT : CAUSE_STEP;
      end
      default: begin
        state_d = S_IDLE;
        cause_d = CAUSE_NONE;
      end
    endcase
  end

  always_comb begin
    pc_d     = retire ? next_addr : pc_q;
    retire_d = retire ? retire_q + 1'b1 : retire_q;
    cycle_d  = active ? cycle_q + 1'b1 : cycle_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      cause_q   <= CAUSE_NONE;
      bp_skip_q <= 1'b0;
      cycle_q   <= '0;
      retire_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cause_q   <= cause_d;
      bp_skip_q <= bp_skip_d;
      cycle_q   <= cycle_d;
      retire_q  <= retire_d;
    end
  end

  assign pc         = pc_q;
  assign cpu_clk_en = retire;
  assign running    = active;
  assign halted     = (state_q == S_HALT);
  assign halt_cause = cause_q;
  assign cycle_cnt  = cycle_q;
  assign retire_cnt = retire_q;

endmodule
